alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
//  Parametrised, handshaked successor of the 8-bit combinational 3-bit-opcode ALU.
//  Registers operands on an input handshake and returns a registered result, a high product word and flags.
//  MUL runs as an iterative shift-add over WIDTH cycles; all other ops complete in one cycle.
//  Sits between an operand/opcode source (sequencer or bench) and a result consumer that may stall.
// PARAMETERS
//  WIDTH  8  operand/result width in bits; legal range >= 2. SHW = $clog2(WIDTH).
// PORTS
//  clk        in   1      single clock, all logic on rising edge
//  reset      in   1      synchronous, active-high reset
//  in_valid   in   1      opcode/a/b valid this cycle
//  in_ready   out  1      block can accept a new operation
//  opcode     in   3      0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR, 7 MUL
//  a          in   WIDTH  operand A (unsigned; signed view for overflow only)
//  b          in   WIDTH  operand B; shift amount for SHL/SHR
//  out_valid  out  1      result/flags valid, held until out_ready
//  out_ready  in   1      consumer accepts the result this cycle
//  res        out  WIDTH  result (MUL: low word of product)
//  res_hi     out  WIDTH  MUL: high word of product; 0 for all other ops
//  flag_z     out  1      res==0 && res_hi==0
//  flag_c     out  1      ADD carry-out; SUB borrow (a<b); SHL/SHR last bit shifted out; else 0
//  flag_v     out  1      ADD/SUB two's-complement signed overflow; else 0
// BEHAVIOUR
//  - Reset (sync, high): state IDLE; in_ready=1; out_valid=0; res, res_hi, flags = 0.
//  - FSM states: IDLE, MUL, DONE.
//  - IDLE: in_ready=1. On in_valid: latch opcode/a/b. Opcodes 0-6: compute and go DONE next edge.
//    Opcode 7: clear product accumulator, count=0, go MUL.
//  - MUL: in_ready=0; each cycle: if multiplier LSB then acc_hi += multiplicand (carry kept); shift {acc} right 1.
//    After exactly WIDTH iterations go DONE. Product is unsigned, 2*WIDTH bits, never truncated.
//  - DONE: out_valid=1, in_ready=0, outputs stable. When out_ready=1: go IDLE, out_valid=0 next cycle.
//  - Latency accept->out_valid: 1 cycle for ops 0-6; WIDTH+1 cycles for MUL.
//  - Throughput: one op per 2 cycles minimum (IDLE, DONE); no new accept while DONE, even if out_ready.
//  - in_valid while in_ready=0 is ignored; source must hold it until in_ready.
//  - ADD/SUB wrap modulo 2^WIDTH. SUB: res=a-b, flag_c=1 iff a<b.
//  - SHL/SHR logical, zero fill. If b >= WIDTH: res=0, flag_c=0. If b==0: res=a, flag_c=0.
//  - AND/OR/XOR: flag_c=flag_v=0. MUL: flag_c=flag_v=0, flag_z on full 2*WIDTH product.
//  - Reset mid-MUL or in DONE: operation aborted, result discarded, IDLE next cycle.
//  - Opcode/a/b inputs may change freely after acceptance; internal copies are used.
// TESTING (WIDTH=8 unless stated)
//  1. Reset, then ADD a=200 b=100 -> 1 cycle later out_valid, res=44, flag_c=1, flag_v=0, flag_z=0.
//  2. SUB a=0x80 b=0x01 -> res=0x7F, flag_c=0, flag_v=1; SUB a=5 b=5 -> res=0, flag_z=1.
//  3. MUL a=255 b=255 -> out_valid exactly 9 cycles after accept, res_hi=0xFE, res=0x01; in_ready=0 throughout.
//  4. SHL a=0x81 b=1 -> res=0x02, flag_c=1; SHR a=0x81 b=8 -> res=0, flag_c=0.
//  5. Hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0, in_valid pulses ignored; release -> IDLE.
//  6. Assert reset at MUL iteration 4 -> next cycle out_valid=0, in_ready=1, res=0; new XOR 0xF0^0x0F -> res=0xFF.
//  Plus 1000 random ops vs reference model for WIDTH=8 and WIDTH=16, with random out_ready stalls.

Source files
------------

// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq - handshaked sequential ALU
//
// Accepts opcode/a/b on an input valid/ready handshake and returns a
// registered result, a high product word and flags on an output valid/ready
// handshake. ADD/SUB/AND/OR/XOR/SHL/SHR finish in one cycle. MUL runs as an
// unsigned shift-add over WIDTH cycles and returns the full 2*WIDTH product.
//
// Ports
//   clk        in   1      rising-edge clock
//   reset      in   1      synchronous, active-high reset
//   in_valid   in   1      opcode/a/b valid this cycle
//   in_ready   out  1      block can accept a new operation
//   opcode     in   3      0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 SHL,6 SHR,7 MUL
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B / shift amount
//   out_valid  out  1      result valid, held until out_ready
//   out_ready  in   1      consumer takes the result this cycle
//   res        out  WIDTH  result (MUL: low product word)
//   res_hi     out  WIDTH  MUL high product word, else 0
//   flag_z     out  1      res == 0 and res_hi == 0
//   flag_c     out  1      ADD carry, SUB borrow, last shifted-out bit
//   flag_v     out  1      ADD/SUB signed overflow
// -----------------------------------------------------------------------------
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic [WIDTH-1:0] res_hi,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v
);

  localparam int SHW = $clog2(WIDTH);

  // WIDTH always fits in WIDTH bits because WIDTH < 2**WIDTH.
  localparam logic [WIDTH-1:0] W_LIMIT  = WIDTH'(WIDTH);
  localparam logic [SHW-1:0]   CNT_LAST = SHW'(WIDTH - 1);
  localparam logic [SHW-1:0]   CNT_ONE  = SHW'(1);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_accept;
  logic             w_mul_last;

  logic [WIDTH-1:0] w_alu_res;
  logic             w_alu_c;
  logic             w_alu_v;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH:0]   w_shl;
  logic [WIDTH:0]   w_shr;
  logic [SHW-1:0]   w_shamt;

  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_acc_hi;
  logic [WIDTH-1:0] r_acc_lo;
  logic [SHW-1:0]   r_cnt;
  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH-1:0] w_hi_nxt;
  logic [WIDTH-1:0] w_lo_nxt;

  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_res_hi;
  logic             r_fz;
  logic             r_fc;
  logic             r_fv;
  logic             r_in_ready;
  logic             r_out_valid;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode plus accept / last-iteration strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_mul_last  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_accept = 1'b1;
          if (opcode == OP_MUL) begin
            w_state_nxt = S_MUL;
          end else begin
            w_state_nxt = S_DONE;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_MUL: begin
        if (r_cnt == CNT_LAST) begin
          w_mul_last  = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_MUL;
        end
      end
      S_DONE: begin
        // out_ready only releases the result; a new op waits for IDLE.
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Single-cycle ops, evaluated straight from the accepted inputs.
  always_comb begin
    w_alu_res = {WIDTH{1'b0}};
    w_alu_c   = 1'b0;
    w_alu_v   = 1'b0;
    w_shamt   = b[SHW-1:0];
    w_sum     = {1'b0, a} + {1'b0, b};
    w_diff    = {1'b0, a} - {1'b0, b};
    // One spare bit on the side the data leaves catches the last bit out.
    w_shl     = {1'b0, a} << w_shamt;
    w_shr     = {a, 1'b0} >> w_shamt;
    case (opcode)
      OP_ADD: begin
        w_alu_res = w_sum[WIDTH-1:0];
        w_alu_c   = w_sum[WIDTH];
        w_alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        w_alu_res = w_diff[WIDTH-1:0];
        w_alu_c   = w_diff[WIDTH];
        w_alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: w_alu_res = a & b;
      OP_OR:  w_alu_res = a | b;
      OP_XOR: w_alu_res = a ^ b;
      OP_SHL: begin
        if (b == {WIDTH{1'b0}}) begin
          w_alu_res = a;
        end else if (b >= W_LIMIT) begin
          w_alu_res = {WIDTH{1'b0}};
        end else begin
          w_alu_res = w_shl[WIDTH-1:0];
          w_alu_c   = w_shl[WIDTH];
        end
      end
      OP_SHR: begin
        if (b == {WIDTH{1'b0}}) begin
          w_alu_res = a;
        end else if (b >= W_LIMIT) begin
          w_alu_res = {WIDTH{1'b0}};
        end else begin
          w_alu_res = w_shr[WIDTH:1];
          w_alu_c   = w_shr[0];
        end
      end
      default: begin
        w_alu_res = {WIDTH{1'b0}};
      end
    endcase
  end

  // One shift-add step: the multiplier sits in acc_lo and drains out of
  // bit 0 while product bits shift in from the top.
  always_comb begin
    if (r_acc_lo[0]) begin
      w_mul_sum = {1'b0, r_acc_hi} + {1'b0, r_mcand};
    end else begin
      w_mul_sum = {1'b0, r_acc_hi};
    end
    w_hi_nxt = w_mul_sum[WIDTH:1];
    w_lo_nxt = {w_mul_sum[0], r_acc_lo[WIDTH-1:1]};
  end

  // Datapath, result and handshake registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mcand     <= {WIDTH{1'b0}};
      r_acc_hi    <= {WIDTH{1'b0}};
      r_acc_lo    <= {WIDTH{1'b0}};
      r_cnt       <= {SHW{1'b0}};
      r_res       <= {WIDTH{1'b0}};
      r_res_hi    <= {WIDTH{1'b0}};
      r_fz        <= 1'b0;
      r_fc        <= 1'b0;
      r_fv        <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_in_ready  <= (w_state_nxt == S_IDLE);
      r_out_valid <= (w_state_nxt == S_DONE);
      if (w_accept) begin
        if (opcode == OP_MUL) begin
          r_mcand  <= a;
          r_acc_lo <= b;
          r_acc_hi <= {WIDTH{1'b0}};
          r_cnt    <= {SHW{1'b0}};
        end else begin
          r_res    <= w_alu_res;
          r_res_hi <= {WIDTH{1'b0}};
          r_fz     <= (w_alu_res == {WIDTH{1'b0}});
          r_fc     <= w_alu_c;
          r_fv     <= w_alu_v;
        end
      end else if (r_state == S_MUL) begin
        r_acc_hi <= w_hi_nxt;
        r_acc_lo <= w_lo_nxt;
        r_cnt    <= r_cnt + CNT_ONE;
        if (w_mul_last) begin
          r_res    <= w_lo_nxt;
          r_res_hi <= w_hi_nxt;
          r_fz     <= ({w_hi_nxt, w_lo_nxt} == {(2*WIDTH){1'b0}});
          r_fc     <= 1'b0;
          r_fv     <= 1'b0;
        end else begin
          r_res    <= r_res;
        end
      end else begin
        r_cnt <= r_cnt;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign res       = r_res;
  assign res_hi    = r_res_hi;
  assign flag_z    = r_fz;
  assign flag_c    = r_fc;
  assign flag_v    = r_fv;

endmodule

// File: tb/tb_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_seq - self-checking bench for alu_seq
//
// Drives a WIDTH=8 and a WIDTH=16 instance (one at a time, selected by sel16)
// with directed and random operations and compares every result against an
// arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        out_ready;
  logic        sel16;
  logic [2:0]  opcode;
  logic [15:0] a;
  logic [15:0] b;

  logic        ir8, ov8, z8, c8, v8;
  logic [7:0]  res8, hi8;
  logic        ir16, ov16, z16, c16, v16;
  logic [15:0] res16, hi16;

  logic        ir, ov, fz, fc, fv;
  logic [15:0] rs, rh;

  int          n_err = 0;
  int          n_chk = 0;
  string       ctx = "init";

  logic [63:0] obs_res, obs_hi;
  logic        obs_z, obs_c, obs_v;
  int          obs_lat;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid & ~sel16), .in_ready(ir8),
    .opcode(opcode), .a(a[7:0]), .b(b[7:0]), .out_valid(ov8),
    .out_ready(out_ready & ~sel16), .res(res8), .res_hi(hi8),
    .flag_z(z8), .flag_c(c8), .flag_v(v8)
  );

  alu_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .in_valid(in_valid & sel16), .in_ready(ir16),
    .opcode(opcode), .a(a), .b(b), .out_valid(ov16),
    .out_ready(out_ready & sel16), .res(res16), .res_hi(hi16),
    .flag_z(z16), .flag_c(c16), .flag_v(v16)
  );

  // View of whichever instance is currently selected.
  always_comb begin
    if (sel16) begin
      ir = ir16; ov = ov16; fz = z16; fc = c16; fv = v16; rs = res16; rh = hi16;
    end else begin
      ir = ir8; ov = ov8; fz = z8; fc = c8; fv = v8;
      rs = {8'd0, res8}; rh = {8'd0, hi8};
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s [%s]: got=%0h expected=%0h", tag, ctx, got, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the operand values.
  function automatic void ref_op(input int w, input logic [2:0] op,
                                 input logic [15:0] av, input logic [15:0] bv,
                                 output logic [63:0] r, output logic [63:0] h,
                                 output logic z, output logic c, output logic v);
    longint m, half, x, y, sx, sy, s;
    m    = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    x    = longint'(av) & m;
    y    = longint'(bv) & m;
    sx   = (x >= half) ? x - (m + 1) : x;
    sy   = (y >= half) ? y - (m + 1) : y;
    r = 64'd0; h = 64'd0; c = 1'b0; v = 1'b0;
    case (op)
      3'd0: begin
        s = x + y; r = s & m; c = (s > m);
        v = ((sx + sy) < -half) || ((sx + sy) > half - 1);
      end
      3'd1: begin
        r = (x - y) & m; c = (x < y);
        v = ((sx - sy) < -half) || ((sx - sy) > half - 1);
      end
      3'd2: r = x & y;
      3'd3: r = x | y;
      3'd4: r = x ^ y;
      3'd5: begin
        if (y == 0) r = x;
        else if (y < w) begin
          r = (x << y) & m; c = (((x >> (w - y)) & 1) != 0);
        end
      end
      3'd6: begin
        if (y == 0) r = x;
        else if (y < w) begin
          r = x >> y; c = (((x >> (y - 1)) & 1) != 0);
        end
      end
      default: begin
        s = x * y; r = s & m; h = s >> w;
      end
    endcase
    z = (r == 0) && (h == 0);
  endfunction

  // One complete transaction: accept, wait for result, stall, release.
  task automatic run_op(input bit s16, input logic [2:0] op, input logic [15:0] av,
                        input logic [15:0] bv, input int stall, input bit noisy);
    int w, lat;
    logic [63:0] er, eh;
    logic ez, ec, ev, busy_rdy;
    w = s16 ? 16 : 8;
    ref_op(w, op, av, bv, er, eh, ez, ec, ev);
    ctx = $sformatf("w%0d op%0d a=%h b=%h", w, op, av, bv);
    @(negedge clk);
    sel16 = s16; in_valid = 1'b1; opcode = op; a = av; b = bv; out_ready = 1'b0;
    #1;
    check_eq("accept_ready", 64'(ir), 64'd1);
    @(posedge clk);
    lat = 1; busy_rdy = 1'b0;
    @(negedge clk);
    // Inputs are free to change once accepted; stray valids must be ignored.
    in_valid = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
    opcode = 3'($urandom); a = 16'($urandom); b = 16'($urandom);
    while (!ov && lat < 40) begin
      if (ir) busy_rdy = 1'b1;
      @(negedge clk);
      lat++;
      in_valid = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    obs_lat = lat; obs_res = 64'(rs); obs_hi = 64'(rh);
    obs_z = fz; obs_c = fc; obs_v = fv;
    check_eq("latency", 64'(lat), (op == 3'd7) ? 64'(w + 1) : 64'd1);
    check_eq("busy_ready", 64'(busy_rdy | ir), 64'd0);
    check_eq("res", 64'(rs), er);
    check_eq("res_hi", 64'(rh), eh);
    check_eq("flag_z", 64'(fz), 64'(ez));
    check_eq("flag_c", 64'(fc), 64'(ec));
    check_eq("flag_v", 64'(fv), 64'(ev));
    busy_rdy = 1'b0;
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      if (ir) busy_rdy = 1'b1;
      in_valid = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      opcode = 3'($urandom); a = 16'($urandom); b = 16'($urandom);
    end
    if (stall > 0) begin
      check_eq("hold_valid", 64'(ov), 64'd1);
      check_eq("hold_ready", 64'(busy_rdy | ir), 64'd0);
      check_eq("hold_res", {rh, rs, 13'd0, fz, fc, fv}, {eh[15:0], er[15:0], 13'd0, ez, ec, ev});
    end
    // Release with in_valid high: DONE must not take a new op.
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b0;
    check_eq("post_valid", 64'(ov), 64'd0);
    check_eq("post_ready", 64'(ir), 64'd1);
  endtask

  initial begin
    bit s16;
    int w;
    logic [2:0]  op;
    logic [15:0] av, bv;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sel16 = 1'b0;
    opcode = 3'd0; a = 16'd0; b = 16'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int s = 0; s < 2; s++) begin
      sel16 = (s == 1);
      #1;
      ctx = $sformatf("reset w%0d", sel16 ? 16 : 8);
      check_eq("rst_ready", 64'(ir), 64'd1);
      check_eq("rst_valid", 64'(ov), 64'd0);
      check_eq("rst_res", {rh, rs}, 64'd0);
      check_eq("rst_flags", 64'({fz, fc, fv}), 64'd0);
    end

    // Directed cases at WIDTH=8.
    run_op(1'b0, 3'd0, 16'd200, 16'd100, 0, 1'b0);
    check_eq("t1_res", obs_res, 64'd44);
    check_eq("t1_flags", 64'({obs_z, obs_c, obs_v}), 64'b010);
    run_op(1'b0, 3'd1, 16'h80, 16'h01, 0, 1'b0);
    check_eq("t2_res", obs_res, 64'h7F);
    check_eq("t2_flags", 64'({obs_z, obs_c, obs_v}), 64'b001);
    run_op(1'b0, 3'd1, 16'd5, 16'd5, 0, 1'b0);
    check_eq("t2b_res_z", {obs_res[62:0], obs_z}, 64'd1);
    run_op(1'b0, 3'd7, 16'd255, 16'd255, 0, 1'b0);
    check_eq("t3_prod", {obs_hi[31:0], obs_res[31:0]}, 64'h000000FE_00000001);
    check_eq("t3_lat", 64'(obs_lat), 64'd9);
    run_op(1'b0, 3'd5, 16'h81, 16'd1, 0, 1'b0);
    check_eq("t4_shl", {obs_res[62:0], obs_c}, 64'h5);
    run_op(1'b0, 3'd6, 16'h81, 16'd8, 0, 1'b0);
    check_eq("t4_shr", {obs_res[62:0], obs_c}, 64'h0);
    run_op(1'b0, 3'd4, 16'h3C, 16'h0F, 5, 1'b1);
    check_eq("t5_res", obs_res, 64'h33);

    // Reset during the fourth MUL iteration aborts the operation.
    ctx = "reset mid-MUL";
    @(negedge clk);
    sel16 = 1'b0; in_valid = 1'b1; opcode = 3'd7; a = 16'h99; b = 16'h77;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("t6_valid", 64'(ov), 64'd0);
    check_eq("t6_ready", 64'(ir), 64'd1);
    check_eq("t6_res", {rh, rs}, 64'd0);
    run_op(1'b0, 3'd4, 16'hF0, 16'h0F, 0, 1'b0);
    check_eq("t6_xor", obs_res, 64'hFF);

    // Random operations with stalls on both widths.
    for (int s = 0; s < 2; s++) begin
      s16 = (s == 1);
      w = s16 ? 16 : 8;
      for (int i = 0; i < 1000; i++) begin
        op = 3'($urandom);
        av = 16'($urandom);
        bv = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, w + 2)) : 16'($urandom);
        run_op(s16, op, av, bv, int'($urandom_range(0, 3)), 1'b1);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
